// File: rtl/disp_output_k_if.sv
// Valid/ready bus that carries one 16-bit fixed-point value (6.10) into the display block.
interface disp_output_k_if;
   logic [15:0] k_in;
   logic        k_valid;
   logic        k_ready;

   modport master (output k_in, output k_valid, input k_ready);
   modport slave  (input k_in, input k_valid, output k_ready);
endinterface

// File: rtl/disp_output_k.sv
// Converts an accepted 6.10 fixed-point value to TT.ff decimal digits and shows them on a
// multiplexed 4-digit common-anode 7-segment display.
module disp_output_k #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic             clk,
   input  logic             rst_n,
   disp_output_k_if.slave   k_bus,
   output logic             busy,
   output logic             done,
   output logic [3:0]       an,
   output logic [6:0]       seg,
   output logic             dp
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   typedef enum logic [1:0] {S_IDLE, S_INT, S_FRAC, S_COMMIT} state_t;

   state_t      state;
   logic [5:0]  int_sh;
   logic [9:0]  frac_r;
   logic [3:0]  bcd_tens, bcd_ones, tenths, hund;
   logic [2:0]  step;
   logic        ready_q, done_q;
   logic [3:0]  disp_tens, disp_ones, disp_tenths, disp_hund;
   logic [CW-1:0] ref_cnt;
   logic [1:0]  idx;

   logic [3:0]  tens_adj, ones_adj;
   logic [13:0] frac_p;
   logic [3:0]  cur_digit;

   // One double-dabble step (add-3 correction) and one multiply-by-10 fraction step
   always_comb begin
      tens_adj = (bcd_tens >= 4'd5) ? bcd_tens + 4'd3 : bcd_tens;
      ones_adj = (bcd_ones >= 4'd5) ? bcd_ones + 4'd3 : bcd_ones;
      frac_p   = 14'(frac_r) * 14'd10;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         int_sh      <= '0;
         frac_r      <= '0;
         bcd_tens    <= '0;
         bcd_ones    <= '0;
         tenths      <= '0;
         hund        <= '0;
         step        <= '0;
         ready_q     <= 1'b1;
         done_q      <= 1'b0;
         disp_tens   <= '0;
         disp_ones   <= '0;
         disp_tenths <= '0;
         disp_hund   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (k_bus.k_valid) begin
                  int_sh   <= k_bus.k_in[15:10];
                  frac_r   <= k_bus.k_in[9:0];
                  bcd_tens <= '0;
                  bcd_ones <= '0;
                  step     <= '0;
                  ready_q  <= 1'b0;
                  state    <= S_INT;
               end
            end
            S_INT: begin
               bcd_tens <= {tens_adj[2:0], ones_adj[3]};
               bcd_ones <= {ones_adj[2:0], int_sh[5]};
               int_sh   <= {int_sh[4:0], 1'b0};
               if (step == 3'd5) begin
                  step  <= '0;
                  state <= S_FRAC;
               end else begin
                  step <= step + 3'd1;
               end
            end
            S_FRAC: begin
               frac_r <= frac_p[9:0];
               if (step == 3'd0) begin
                  tenths <= frac_p[13:10];
                  step   <= 3'd1;
               end else begin
                  hund  <= frac_p[13:10];
                  state <= S_COMMIT;
               end
            end
            S_COMMIT: begin
               disp_tens   <= bcd_tens;
               disp_ones   <= bcd_ones;
               disp_tenths <= tenths;
               disp_hund   <= hund;
               done_q      <= 1'b1;
               ready_q     <= 1'b1;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign k_bus.k_ready = ready_q;
   assign busy          = ~ready_q;
   assign done          = done_q;

   // Free-running digit scan, independent of the conversion FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_cnt <= '0;
         idx     <= '0;
      end else if (ref_cnt == CW'(REFRESH_DIV - 1)) begin
         ref_cnt <= '0;
         idx     <= idx + 2'd1;
      end else begin
         ref_cnt <= ref_cnt + CW'(1);
      end
   end

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0: seg_decode = 7'h40;
         4'd1: seg_decode = 7'h79;
         4'd2: seg_decode = 7'h24;
         4'd3: seg_decode = 7'h30;
         4'd4: seg_decode = 7'h19;
         4'd5: seg_decode = 7'h12;
         4'd6: seg_decode = 7'h02;
         4'd7: seg_decode = 7'h78;
         4'd8: seg_decode = 7'h00;
         4'd9: seg_decode = 7'h10;
         default: seg_decode = 7'h7F;
      endcase
   endfunction

   always_comb begin
      case (idx)
         2'd0:    cur_digit = disp_hund;
         2'd1:    cur_digit = disp_tenths;
         2'd2:    cur_digit = disp_ones;
         default: cur_digit = disp_tens;
      endcase
      an  = ~(4'b0001 << idx);
      dp  = (idx != 2'd2);
      // A zero tens digit is blanked rather than shown as a leading zero
      if (idx == 2'd3 && disp_tens == 4'd0)
         seg = 7'h7F;
      else
         seg = seg_decode(cur_digit);
   end

endmodule

// File: tb/tb_disp_output_k.sv
// Randomised scoreboard bench for disp_output_k: a decimal reference model predicts the digits
// and commit time, and a negedge monitor checks done timing and the scanned display every cycle.
module tb_disp_output_k;

   localparam int RD = 4;

   logic clk;
   logic rst_n;
   logic busy, done, dp;
   logic [3:0] an;
   logic [6:0] seg;

   disp_output_k_if kif ();

   disp_output_k #(.REFRESH_DIV(RD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .k_bus (kif.slave),
      .busy  (busy),
      .done  (done),
      .an    (an),
      .seg   (seg),
      .dp    (dp)
   );

   typedef struct {
      int tens;
      int ones;
      int tenths;
      int hund;
      int due;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   pcnt     = 0;
   int   last_acc = -1;
   int   m_tens = 0, m_ones = 0, m_tenths = 0, m_hund = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [15:0] k, input int due);
      exp_t e;
      int ip, fr, two;
      ip  = int'(k[15:10]);
      fr  = int'(k[9:0]);
      two = (fr * 100) / 1024;
      e.tens   = ip / 10;
      e.ones   = ip % 10;
      e.tenths = two / 10;
      e.hund   = two % 10;
      e.due    = due;
      return e;
   endfunction

   function automatic logic [6:0] seg_of(input int d);
      logic [6:0] tab [10];
      tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      return tab[d];
   endfunction

   // Edge counter since reset release plus the accept recorder that feeds the scoreboard
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt = 0;
         exp_q.delete();
         m_tens = 0; m_ones = 0; m_tenths = 0; m_hund = 0;
      end else begin
         pcnt++;
         if (kif.k_valid && kif.k_ready) begin
            exp_q.push_back(model(kif.k_in, pcnt + 9));
            last_acc = pcnt;
         end
      end
   end

   always @(negedge clk) begin
      int e_idx, e_dig;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      exp_t e;
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            checkOutput("done_unexpected", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            checkOutput("done_latency", pcnt, e.due);
            m_tens = e.tens; m_ones = e.ones; m_tenths = e.tenths; m_hund = e.hund;
         end
      end
      if (!rst_n) begin
         checkOutput("reset_k_ready", kif.k_ready, 32'd1);
         checkOutput("reset_done", done, 32'd0);
      end
      e_idx = (pcnt / RD) % 4;
      e_an  = ~(4'b0001 << e_idx);
      case (e_idx)
         0:       e_dig = m_hund;
         1:       e_dig = m_tenths;
         2:       e_dig = m_ones;
         default: e_dig = m_tens;
      endcase
      e_seg = (e_idx == 3 && m_tens == 0) ? 7'h7F : seg_of(e_dig);
      checkOutput("an", an, e_an);
      checkOutput("seg", seg, e_seg);
      checkOutput("dp", dp, (e_idx == 2) ? 32'd0 : 32'd1);
      checkOutput("busy", busy, (kif.k_ready === 1'b1) ? 32'd0 : 32'd1);
   end

   task automatic applyStimulus(input logic [15:0] k, input bit drop_valid);
      int t;
      @(negedge clk);
      kif.k_in    = k;
      kif.k_valid = 1'b1;
      t = 0;
      while (kif.k_ready !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) checkOutput("accept_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1;
      if (drop_valid) kif.k_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int first_acc;
      logic [15:0] dir [5];
      dir = '{16'h2000, 16'h1400, 16'h0200, 16'h0001, 16'hFFFF};
      rst_n       = 1'b0;
      kif.k_in    = '0;
      kif.k_valid = 1'b0;
      idle(3);
      #2 rst_n = 1'b1;
      idle(20);

      foreach (dir[i]) begin
         applyStimulus(dir[i], 1'b1);
         idle(22);
      end

      // Mid-frame reset: display must fall back to zero with the tens digit blanked
      @(negedge clk);
      #2 rst_n = 1'b0;
      idle(3);
      #2 rst_n = 1'b1;
      idle(18);

      // Valid held through busy with k_in changed at E3: second accept exactly 10 edges later
      applyStimulus(16'h2C00, 1'b0);
      first_acc = last_acc;
      repeat (2) @(posedge clk);
      #1 kif.k_in = 16'h0C00;
      applyStimulus(16'h0C00, 1'b1);
      checkOutput("accept_spacing", last_acc - first_acc, 32'd10);
      idle(22);

      // Reset asserted at E5 of a conversion: no done pulse may follow
      applyStimulus(16'hABCD, 1'b1);
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      idle(2);
      #2 rst_n = 1'b1;
      idle(20);

      for (int i = 0; i < 20; i++) begin
         applyStimulus(16'($urandom), 1'b1);
         if ($urandom_range(0, 1) == 1) idle(20);
      end
      idle(30);
      checkOutput("pending_results", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
